// File: rtl/inertial_integrator_cal.sv
// Single-axis pitch integrator with learned gyro bias, accelerometer fusion
// and a saturating fixed-point accumulator.
module inertial_integrator_cal #(
   parameter int              IN_W      = 16,
   parameter int              FRAC_W    = 11,
   parameter logic [IN_W-1:0] AZ_OFFSET = 'h00A0,
   parameter int              ACC_SCALE = 328,
   parameter int              ACC_SHIFT = 13,
   parameter int              FUSE_HI   = 16384,
   parameter int              FUSE_LO   = 1024,
   parameter int              CAL_LOG2  = 4,
   parameter int              SETTLE_N  = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            vld,
   input  logic            cal_req,
   input  logic [IN_W-1:0] ptch_rt,
   input  logic [IN_W-1:0] AZ,
   output logic [IN_W-1:0] ptch,
   output logic            ptch_vld,
   output logic            cal_done,
   output logic [IN_W-1:0] rt_offset
);

   localparam int INT_W  = IN_W + FRAC_W;
   localparam int SUM_W  = INT_W + 2;
   localparam int CAL_W  = IN_W + CAL_LOG2;
   localparam int PROD_W = IN_W + 33;
   localparam int SET_W  = $clog2(SETTLE_N + 1);

   localparam logic [1:0] ST_CAL    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   localparam logic signed [PROD_W-1:0] SCALE_EXT = PROD_W'(ACC_SCALE);
   localparam logic signed [SUM_W-1:0]  SAT_MAX   = {3'b000, {(INT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0]  SAT_MIN   = {3'b111, {(INT_W-1){1'b0}}};

   logic [1:0]              state_reg;
   logic signed [INT_W-1:0] integ_reg;
   logic signed [CAL_W-1:0] cal_sum_reg;
   logic [CAL_LOG2-1:0]     cal_cnt_reg;
   logic [SET_W-1:0]        settle_cnt_reg;
   logic [IN_W-1:0]         rt_offset_reg;
   logic                    ptch_vld_reg;

   logic signed [IN_W:0]    rt_c;
   logic signed [IN_W:0]    acc_c;
   logic signed [PROD_W-1:0] prod;
   logic signed [IN_W-1:0]  ptch_acc;
   logic signed [IN_W-1:0]  ptch_cur;
   logic signed [SUM_W-1:0] fuse_mag;
   logic signed [SUM_W-1:0] fuse;
   logic signed [SUM_W-1:0] sum;
   logic signed [INT_W-1:0] integ_next;
   logic signed [CAL_W-1:0] cal_sample;
   logic signed [CAL_W-1:0] cal_total;
   logic [IN_W-1:0]         rt_offset_next;

   // Both differences are one bit wider than the inputs so they never wrap.
   assign rt_c  = $signed({ptch_rt[IN_W-1], ptch_rt}) - $signed({rt_offset_reg[IN_W-1], rt_offset_reg});
   assign acc_c = $signed({AZ[IN_W-1], AZ}) - $signed({AZ_OFFSET[IN_W-1], AZ_OFFSET});

   assign prod     = $signed({{(PROD_W-IN_W-1){acc_c[IN_W]}}, acc_c}) * SCALE_EXT;
   assign ptch_acc = IN_W'(prod >>> ACC_SHIFT);
   assign ptch_cur = integ_reg[INT_W-1:FRAC_W];

   assign fuse_mag = (state_reg == ST_SETTLE) ? SUM_W'(FUSE_HI) : SUM_W'(FUSE_LO);
   assign fuse     = (ptch_acc > ptch_cur) ? fuse_mag : -fuse_mag;

   assign sum = $signed({{2{integ_reg[INT_W-1]}}, integ_reg})
              - $signed({{(SUM_W-IN_W-1){rt_c[IN_W]}}, rt_c})
              + fuse;

   always_comb begin
      integ_next = INT_W'(sum);
      if (sum > SAT_MAX) begin
         integ_next = INT_W'(SAT_MAX);
      end else if (sum < SAT_MIN) begin
         integ_next = INT_W'(SAT_MIN);
      end
   end

   // The final calibration sample is folded in combinationally so the
   // average is ready on the same edge that ends calibration.
   assign cal_sample     = $signed({{CAL_LOG2{ptch_rt[IN_W-1]}}, ptch_rt});
   assign cal_total      = cal_sum_reg + cal_sample;
   assign rt_offset_next = IN_W'(cal_total >>> CAL_LOG2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_CAL;
         integ_reg      <= '0;
         cal_sum_reg    <= '0;
         cal_cnt_reg    <= '0;
         settle_cnt_reg <= '0;
         rt_offset_reg  <= '0;
         ptch_vld_reg   <= 1'b0;
      end else begin
         ptch_vld_reg <= 1'b0;
         if (cal_req) begin
            state_reg   <= ST_CAL;
            cal_sum_reg <= '0;
            cal_cnt_reg <= '0;
            integ_reg   <= '0;
         end else if (vld) begin
            case (state_reg)
               ST_CAL: begin
                  if (cal_cnt_reg == '1) begin
                     rt_offset_reg  <= rt_offset_next;
                     state_reg      <= ST_SETTLE;
                     settle_cnt_reg <= '0;
                     integ_reg      <= '0;
                     cal_sum_reg    <= '0;
                     cal_cnt_reg    <= '0;
                  end else begin
                     cal_sum_reg <= cal_total;
                     cal_cnt_reg <= cal_cnt_reg + 1'b1;
                  end
               end
               ST_SETTLE: begin
                  integ_reg      <= integ_next;
                  ptch_vld_reg   <= 1'b1;
                  settle_cnt_reg <= settle_cnt_reg + 1'b1;
                  if (settle_cnt_reg == SET_W'(SETTLE_N - 1)) begin
                     state_reg <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  integ_reg    <= integ_next;
                  ptch_vld_reg <= 1'b1;
               end
               default: begin
                  state_reg <= ST_CAL;
               end
            endcase
         end
      end
   end

   assign ptch      = ptch_cur;
   assign ptch_vld  = ptch_vld_reg;
   assign cal_done  = (state_reg != ST_CAL);
   assign rt_offset = rt_offset_reg;

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Scoreboard bench for inertial_integrator_cal: a plain-arithmetic model
// predicts every pitch update, a monitor pops and compares on ptch_vld.
module tb_inertial_integrator_cal;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vld = 1'b0;
   logic        cal_req = 1'b0;
   logic [15:0] ptch_rt = '0;
   logic [15:0] AZ = '0;
   logic [15:0] ptch;
   logic        ptch_vld;
   logic        cal_done;
   logic [15:0] rt_offset;

   int checks = 0;
   int failures = 0;
   int txn_n = 0;

   // model state: mode 0 = calibrating, 1 = settling, 2 = running
   int      m_mode = 0;
   longint  m_cal_q[$];
   longint  m_off = 0;
   longint  m_integ = 0;
   int      m_settle = 0;
   longint  exp_q[$];

   inertial_integrator_cal dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld       (vld),
      .cal_req   (cal_req),
      .ptch_rt   (ptch_rt),
      .AZ        (AZ),
      .ptch      (ptch),
      .ptch_vld  (ptch_vld),
      .cal_done  (cal_done),
      .rt_offset (rt_offset)
   );

   always #5 clk = ~clk;

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and advance the model to the post-edge state.
   task automatic step(input bit v, input bit c, input logic [15:0] r, input logic [15:0] a);
      longint rs, as_, total, rtc, pa, pc, fz;
      logic signed [15:0] pa16;
      @(negedge clk);
      vld = v; cal_req = c; ptch_rt = r; AZ = a;
      rs  = longint'($signed(r));
      as_ = longint'($signed(a));
      if (c) begin
         m_mode = 0;
         m_cal_q.delete();
         m_integ = 0;
      end else if (v) begin
         if (m_mode == 0) begin
            m_cal_q.push_back(rs);
            if (m_cal_q.size() == 16) begin
               total = 0;
               foreach (m_cal_q[k]) total += m_cal_q[k];
               m_off = fdiv(total, 16);
               m_cal_q.delete();
               m_mode = 1;
               m_settle = 0;
               m_integ = 0;
            end
         end else begin
            rtc  = rs - m_off;
            pa16 = 16'(fdiv((as_ - 160) * 328, 8192));
            pa   = longint'(pa16);
            pc   = fdiv(m_integ, 2048);
            fz   = (m_mode == 1) ? 16384 : 1024;
            if (!(pa > pc)) fz = -fz;
            m_integ = m_integ - rtc + fz;
            if (m_integ > 67108863) m_integ = 67108863;
            if (m_integ < -67108864) m_integ = -67108864;
            exp_q.push_back(fdiv(m_integ, 2048));
            if (m_mode == 1) begin
               m_settle++;
               if (m_settle == 64) m_mode = 2;
            end
         end
      end
   endtask

   task automatic settle_after_edge();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one line per pitch transaction, plus per-cycle state checks.
   initial begin
      wait (rst_n === 1'b1);
      forever begin
         @(posedge clk);
         #1;
         if (ptch_vld) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ptch_vld: got ptch_vld=1 expected 0 at %0t", $time);
            end else begin
               longint e;
               e = exp_q.pop_front();
               txn_n++;
               $display("txn %0d ptch=%0d expected=%0d", txn_n, $signed(ptch), e);
               chk("ptch_txn", longint'($signed(ptch)), e);
            end
         end
         chk("ptch_cycle", longint'($signed(ptch)), fdiv(m_integ, 2048));
         chk("cal_done", longint'(cal_done), (m_mode != 0) ? 1 : 0);
         chk("rt_offset", longint'($signed(rt_offset)), m_off);
      end
   end

   initial begin
      longint exp_d;
      #2 rst_n = 1'b0;
      #2;
      chk("reset_ptch", longint'(ptch), 0);
      chk("reset_ptch_vld", longint'(ptch_vld), 0);
      chk("reset_cal_done", longint'(cal_done), 0);
      chk("reset_rt_offset", longint'(rt_offset), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // calibration on a constant rate, with idle gaps
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 16'h0050, 16'h0000);
         if (i % 3 == 0) step(1'b0, 1'b0, 16'h1234, 16'h4321);
      end
      settle_after_edge();
      chk("cal1_rt_offset", longint'(rt_offset), 80);
      chk("cal1_cal_done", longint'(cal_done), 1);

      // settle oscillation of +/-16384, then run oscillation of +/-1024
      for (int i = 1; i <= 70; i++) begin
         step(1'b1, 1'b0, 16'h0050, 16'h00A0);
         settle_after_edge();
         if (i <= 64) exp_d = (i % 2 == 1) ? -8 : 0;
         else         exp_d = ((i - 64) % 2 == 1) ? -1 : 0;
         chk("oscillation", longint'($signed(ptch)), exp_d);
      end

      // large negative rate drives the integrator into positive saturation
      for (int i = 0; i < 2200; i++) step(1'b1, 1'b0, 16'h8000, 16'h00A0);
      settle_after_edge();
      chk("saturated_ptch", longint'(ptch), 32767);

      // recalibration request coincident with a sample
      step(1'b1, 1'b1, 16'h8000, 16'h00A0);
      settle_after_edge();
      chk("calreq_ptch", longint'(ptch), 0);
      chk("calreq_cal_done", longint'(cal_done), 0);
      chk("calreq_ptch_vld", longint'(ptch_vld), 0);
      chk("calreq_rt_offset_kept", longint'(rt_offset), 80);

      // floor behaviour of the average: 3,-4 alternating sums to -8
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, (i % 2 == 0) ? 16'h0003 : 16'hFFFC, 16'h0000);
      settle_after_edge();
      chk("cal2_rt_offset", longint'($signed(rt_offset)), -1);
      chk("cal2_cal_done", longint'(cal_done), 1);

      // randomized traffic including recalibration in every state
      for (int i = 0; i < 1500; i++) begin
         bit v, c;
         logic [15:0] r, a;
         v = ($urandom_range(0, 1) == 1);
         c = ($urandom_range(0, 99) == 0);
         r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(70 + $urandom_range(0, 20));
         a = 16'($urandom);
         step(v, c, r, a);
      end

      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      settle_after_edge();
      chk("scoreboard_drained", longint'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
